// File: rtl/haar_feature_seq.sv
// -----------------------------------------------------------------------------
// haar_feature_seq
//
// Sequencer for the rectangle-sum datapath of the cascade classifier.
// It takes one Haar rectangle descriptor at a time and issues the four
// integral-image corner addresses in the order the rect-sum datapath signs
// them (+ - + -). It then presents the rectangle weight and collects the
// weighted rectangle sum. All rectangles of one feature are accumulated into
// a single feature sum for the stage comparator.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rect_*            descriptor stream in (valid/ready): x, y, w, h,
//                     signed weight, last-rectangle-of-feature flag
//   addr_valid/ready  corner address out to the integral memory
//   addr              registered corner address (row*IMG_W + col, truncated)
//   weight_valid/ready, weight
//                     registered rectangle weight out to the rect-sum datapath
//   rsum_valid/ready, rsum_data
//                     weighted rectangle sum in from the datapath
//   feat_valid/ready, feat_sum
//                     accumulated feature sum out
//   err               sticky: a descriptor exceeded the window bounds
//   busy              high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module haar_feature_seq #(
  parameter int IMG_W    = 25,
  parameter int W_ADDR   = 10,
  parameter int W_COORD  = 5,
  parameter int W_WEIGHT = 3,
  parameter int W_RSUM   = 35,
  parameter int W_FEAT   = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rect_valid,
  output logic                       rect_ready,
  input  logic [W_COORD-1:0]         rect_x,
  input  logic [W_COORD-1:0]         rect_y,
  input  logic [W_COORD-1:0]         rect_w,
  input  logic [W_COORD-1:0]         rect_h,
  input  logic signed [W_WEIGHT-1:0] rect_weight,
  input  logic                       rect_last,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic [W_ADDR-1:0]          addr,
  output logic                       weight_valid,
  input  logic                       weight_ready,
  output logic signed [W_WEIGHT-1:0] weight,
  input  logic                       rsum_valid,
  output logic                       rsum_ready,
  input  logic signed [W_RSUM-1:0]   rsum_data,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic signed [W_FEAT-1:0]   feat_sum,
  output logic                       err,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Largest legal corner coordinate. Row/column IMG_W-1 is the last one
  // that exists in the padded integral window.
  localparam logic [W_COORD:0] MAX_COORD = (W_COORD + 1)'(IMG_W - 1);

  state_t                     state, state_next;
  logic [W_COORD-1:0]         x_r, y_r, w_r, h_r;
  logic                       last_r;
  logic [1:0]                 corner;
  logic                       first_r;
  logic signed [W_FEAT-1:0]   acc;
  logic signed [W_FEAT-1:0]   acc_sum;
  logic [W_COORD:0]           in_xw, in_yh;
  logic                       in_oob;

  logic rect_fire, addr_fire, weight_fire, rsum_fire, feat_fire;

  // Corner order matches the datapath sign pattern: 0:(x,y) + 1:(x+w,y) -
  // 2:(x+w,y+h) + 3:(x,y+h) -. The address is formed at full width before
  // truncation, so out-of-window corners wrap rather than saturate.
  function automatic logic [W_ADDR-1:0] corner_addr(
    input logic [1:0]         c,
    input logic [W_COORD-1:0] cx,
    input logic [W_COORD-1:0] cy,
    input logic [W_COORD-1:0] cw,
    input logic [W_COORD-1:0] ch
  );
    logic [W_COORD:0] col;
    logic [W_COORD:0] row;
    logic [31:0]      full;
    col  = (c == 2'd1 || c == 2'd2) ? ({1'b0, cx} + {1'b0, cw}) : {1'b0, cx};
    row  = (c == 2'd2 || c == 2'd3) ? ({1'b0, cy} + {1'b0, ch}) : {1'b0, cy};
    full = 32'(row) * 32'(IMG_W) + 32'(col);
    return full[W_ADDR-1:0];
  endfunction

  assign rect_fire   = rect_valid & rect_ready;
  assign addr_fire   = addr_valid & addr_ready;
  assign weight_fire = weight_valid & weight_ready;
  assign rsum_fire   = rsum_valid & rsum_ready;
  assign feat_fire   = feat_valid & feat_ready;

  assign in_xw  = {1'b0, rect_x} + {1'b0, rect_w};
  assign in_yh  = {1'b0, rect_y} + {1'b0, rect_h};
  assign in_oob = (in_xw > MAX_COORD) | (in_yh > MAX_COORD);

  assign acc_sum = acc + {{(W_FEAT - W_RSUM){rsum_data[W_RSUM-1]}}, rsum_data};

  assign busy = (state != IDLE);

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next; otherwise a
    // latch is inferred for the hold case.
    state_next = state;
    case (state)
      IDLE:  if (rect_fire) state_next = ISSUE;
      ISSUE: if (addr_fire && corner == 2'd3) state_next = WAIT;
      WAIT:  if (rsum_fire) state_next = last_r ? DONE : IDLE;
      DONE:  if (feat_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered outputs. Handshake outputs are flops so
  // that they read 0 while reset is asserted. As a result rect_ready opens
  // one cycle after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rect_ready   <= 1'b0;
      x_r          <= '0;
      y_r          <= '0;
      w_r          <= '0;
      h_r          <= '0;
      last_r       <= 1'b0;
      corner       <= 2'd0;
      first_r      <= 1'b1;
      acc          <= '0;
      addr_valid   <= 1'b0;
      addr         <= '0;
      weight_valid <= 1'b0;
      weight       <= '0;
      rsum_ready   <= 1'b0;
      feat_valid   <= 1'b0;
      feat_sum     <= '0;
      err          <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values,
      // independent of statement order in this block.
      state      <= state_next;
      rect_ready <= (state_next == IDLE);

      if (rect_fire) begin
        x_r        <= rect_x;
        y_r        <= rect_y;
        w_r        <= rect_w;
        h_r        <= rect_h;
        weight     <= rect_weight;
        last_r     <= rect_last;
        corner     <= 2'd0;
        addr       <= corner_addr(2'd0, rect_x, rect_y, rect_w, rect_h);
        addr_valid <= 1'b1;
        first_r    <= 1'b0;
        if (first_r) acc <= '0;
        if (in_oob)  err <= 1'b1;
      end

      if (addr_fire) begin
        if (corner == 2'd3) begin
          addr_valid   <= 1'b0;
          weight_valid <= 1'b1;
          rsum_ready   <= 1'b1;
        end else begin
          corner <= corner + 2'd1;
          addr   <= corner_addr(corner + 2'd1, x_r, y_r, w_r, h_r);
        end
      end

      if (weight_fire) weight_valid <= 1'b0;

      // Taking the sum ends the rectangle. A weight still pending at that
      // point is withdrawn so that it does not leak into the next rectangle.
      if (rsum_fire) begin
        acc          <= acc_sum;
        rsum_ready   <= 1'b0;
        weight_valid <= 1'b0;
        if (last_r) begin
          feat_valid <= 1'b1;
          feat_sum   <= acc_sum;
        end
      end

      if (feat_fire) begin
        feat_valid <= 1'b0;
        first_r    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_haar_feature_seq.sv
// -----------------------------------------------------------------------------
// tb_haar_feature_seq
//
// Scoreboard bench for haar_feature_seq. Stimulus tasks push hand-computed
// expected addresses, weights and feature sums into queues. A monitor pops
// and compares them on every output handshake, and also checks that the
// outputs stay stable under backpressure.
// -----------------------------------------------------------------------------
module tb_haar_feature_seq;

  logic               clk;
  logic               rst_n;
  logic               rect_valid;
  logic               rect_ready;
  logic [4:0]         rect_x, rect_y, rect_w, rect_h;
  logic signed [2:0]  rect_weight;
  logic               rect_last;
  logic               addr_valid;
  logic               addr_ready;
  logic [9:0]         addr;
  logic               weight_valid;
  logic               weight_ready;
  logic signed [2:0]  weight;
  logic               rsum_valid;
  logic               rsum_ready;
  logic signed [34:0] rsum_data;
  logic               feat_valid;
  logic               feat_ready;
  logic signed [36:0] feat_sum;
  logic               err;
  logic               busy;

  haar_feature_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rect_valid   (rect_valid),
    .rect_ready   (rect_ready),
    .rect_x       (rect_x),
    .rect_y       (rect_y),
    .rect_w       (rect_w),
    .rect_h       (rect_h),
    .rect_weight  (rect_weight),
    .rect_last    (rect_last),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .weight       (weight),
    .rsum_valid   (rsum_valid),
    .rsum_ready   (rsum_ready),
    .rsum_data    (rsum_data),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .feat_sum     (feat_sum),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0]         addr_q[$];
  logic signed [2:0]  wt_q[$];
  logic signed [36:0] feat_q[$];
  int                 addr_accepts = 0;
  int                 addr_mode = 0;
  int                 addr_phase = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // addr_ready pattern: mode 0 always ready, mode 1 repeats 1,0,0.
  always @(posedge clk) begin
    #1;
    if (addr_mode == 0) addr_ready = 1'b1;
    else                addr_ready = ((addr_phase % 3) == 0);
    addr_phase++;
  end

  // Monitor: sample on the falling edge, where all DUT outputs are settled.
  logic [9:0]         exp_addr, prev_addr;
  logic signed [2:0]  exp_wt, prev_wt;
  logic signed [36:0] exp_feat, prev_feat;
  bit                 addr_stall, wt_stall, feat_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      addr_stall = 1'b0;
      wt_stall   = 1'b0;
      feat_stall = 1'b0;
    end else begin
      if (addr_stall && addr_valid) check("addr_hold", longint'(addr), longint'(prev_addr));
      if (wt_stall && weight_valid) check("weight_hold", longint'(weight), longint'(prev_wt));
      if (feat_stall && feat_valid) check("feat_hold", longint'(feat_sum), longint'(prev_feat));

      if (addr_valid && addr_ready) begin
        addr_accepts++;
        if (addr_q.size() == 0) check("addr_unexpected", longint'(addr), -1);
        else begin
          exp_addr = addr_q.pop_front();
          check("addr", longint'(addr), longint'(exp_addr));
        end
      end
      if (weight_valid && weight_ready) begin
        if (wt_q.size() == 0) check("weight_unexpected", longint'(weight), -99);
        else begin
          exp_wt = wt_q.pop_front();
          check("weight", longint'(weight), longint'(exp_wt));
        end
      end
      if (feat_valid && feat_ready) begin
        if (feat_q.size() == 0) check("feat_unexpected", longint'(feat_sum), -1);
        else begin
          exp_feat = feat_q.pop_front();
          check("feat_sum", longint'(feat_sum), longint'(exp_feat));
        end
      end

      addr_stall = addr_valid && !addr_ready;
      wt_stall   = weight_valid && !weight_ready;
      feat_stall = feat_valid && !feat_ready;
      prev_addr  = addr;
      prev_wt    = weight;
      prev_feat  = feat_sum;
    end
  end

  // All stimulus tasks start and end at posedge + #1.
  task automatic send_rect(input logic [4:0] x, input logic [4:0] y,
                           input logic [4:0] w, input logic [4:0] h,
                           input logic signed [2:0] wt, input logic last,
                           input logic [9:0] a0, input logic [9:0] a1,
                           input logic [9:0] a2, input logic [9:0] a3);
    int n = 0;
    addr_q.push_back(a0);
    addr_q.push_back(a1);
    addr_q.push_back(a2);
    addr_q.push_back(a3);
    wt_q.push_back(wt);
    while (!rect_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) timeout("rect_ready");
    rect_valid = 1'b1;
    rect_x = x; rect_y = y; rect_w = w; rect_h = h;
    rect_weight = wt; rect_last = last;
    @(posedge clk); #1;
    rect_valid = 1'b0;
  endtask

  task automatic give_rsum(input logic signed [34:0] val);
    int n = 0;
    while (!rsum_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) timeout("rsum_ready");
    rsum_valid = 1'b1;
    rsum_data  = val;
    @(posedge clk); #1;
    rsum_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) timeout("idle");
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0;
    rect_valid = 1'b0; rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
    rect_weight = '0; rect_last = 1'b0;
    addr_ready = 1'b1; weight_ready = 1'b1; feat_ready = 1'b1;
    rsum_valid = 1'b0; rsum_data = '0;
    #12;
    check("rst_rect_ready", longint'(rect_ready), 0);
    check("rst_addr_valid", longint'(addr_valid), 0);
    check("rst_addr", longint'(addr), 0);
    check("rst_weight_valid", longint'(weight_valid), 0);
    check("rst_weight", longint'(weight), 0);
    check("rst_rsum_ready", longint'(rsum_ready), 0);
    check("rst_feat_valid", longint'(feat_valid), 0);
    check("rst_feat_sum", longint'(feat_sum), 0);
    check("rst_err", longint'(err), 0);
    check("rst_busy", longint'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    check("idle_rect_ready", longint'(rect_ready), 1);

    // Single rectangle: four consecutive addresses, then the weight and the sum.
    feat_q.push_back(-37'sd163840);
    feat_ready = 1'b0;
    send_rect(5'd2, 5'd3, 5'd4, 5'd5, -3'sd1, 1'b1, 10'd77, 10'd81, 10'd206, 10'd202);
    check("t1_c0", longint'(addr), 77);  step(1);
    check("t1_c1", longint'(addr), 81);  step(1);
    check("t1_c2", longint'(addr), 206); step(1);
    check("t1_c3", longint'(addr), 202); step(1);
    check("t1_weight_valid", longint'(weight_valid), 1);
    check("t1_weight", longint'(weight), -1);
    check("t1_rsum_ready", longint'(rsum_ready), 1);
    give_rsum(-35'sd163840);
    step(3);
    check("t1_feat_held", longint'(feat_valid), 1);
    feat_ready = 1'b1;
    wait_idle();

    // Two-rectangle feature with address backpressure and an ignored rsum pulse.
    addr_mode = 1;
    feat_q.push_back(37'sd2000);
    send_rect(5'd0, 5'd0, 5'd2, 5'd2, -3'sd1, 1'b0, 10'd0, 10'd2, 10'd52, 10'd50);
    rsum_valid = 1'b1;
    rsum_data  = 35'sd12345;
    check("t2_rsum_ready_issue", longint'(rsum_ready), 0);
    step(1);
    rsum_valid = 1'b0;
    give_rsum(-35'sd1000);
    send_rect(5'd1, 5'd1, 5'd3, 5'd1, 3'sd2, 1'b1, 10'd26, 10'd29, 10'd54, 10'd51);
    feat_ready = 1'b0;
    give_rsum(35'sd3000);
    for (int i = 0; i < 5; i++) begin
      check("t2_feat_valid", longint'(feat_valid), 1);
      check("t2_feat_sum", longint'(feat_sum), 2000);
      check("t2_rect_ready", longint'(rect_ready), 0);
      step(1);
    end
    feat_ready = 1'b1;
    wait_idle();
    addr_mode = 0;

    // The next feature starts from a cleared accumulator.
    feat_q.push_back(37'sd5);
    send_rect(5'd0, 5'd0, 5'd1, 5'd1, 3'sd1, 1'b1, 10'd0, 10'd1, 10'd26, 10'd25);
    give_rsum(35'sd5);
    wait_idle();

    // Out of bounds (x+w=28): err is set, and the weight is held under backpressure.
    check("t4_err_before", longint'(err), 0);
    weight_ready = 1'b0;
    feat_q.push_back(37'sd10);
    send_rect(5'd20, 5'd3, 5'd8, 5'd2, 3'sd1, 1'b1, 10'd95, 10'd103, 10'd153, 10'd145);
    check("t4_err_set", longint'(err), 1);
    begin
      int n = 0;
      while (!weight_valid && n < 50) begin step(1); n++; end
      if (n >= 50) timeout("weight_valid");
    end
    step(3);
    check("t4_weight_still_valid", longint'(weight_valid), 1);
    weight_ready = 1'b1;
    give_rsum(35'sd10);
    wait_idle();
    check("t4_err_sticky", longint'(err), 1);

    // Address truncation: row 62 * 25 + 62 = 1612 wraps to 588.
    feat_q.push_back(37'sd77);
    send_rect(5'd31, 5'd31, 5'd31, 5'd31, 3'sd3, 1'b1, 10'd806, 10'd837, 10'd588, 10'd557);
    give_rsum(35'sd77);
    wait_idle();

    // Async reset in the middle of ISSUE, after corner 1 has been accepted.
    send_rect(5'd0, 5'd0, 5'd1, 5'd1, 3'sd1, 1'b0, 10'd0, 10'd1, 10'd26, 10'd25);
    give_rsum(35'sd500);
    base = addr_accepts;
    send_rect(5'd2, 5'd3, 5'd4, 5'd5, 3'sd1, 1'b1, 10'd77, 10'd81, 10'd206, 10'd202);
    begin
      int n = 0;
      while (addr_accepts < base + 2 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) timeout("corner1_accept");
    end
    rst_n = 1'b0;
    #1;
    check("ar_addr_valid", longint'(addr_valid), 0);
    check("ar_addr", longint'(addr), 0);
    check("ar_busy", longint'(busy), 0);
    check("ar_rect_ready", longint'(rect_ready), 0);
    check("ar_weight_valid", longint'(weight_valid), 0);
    check("ar_err", longint'(err), 0);
    addr_q.delete();
    wt_q.delete();
    step(1);
    rst_n = 1'b1;
    feat_q.push_back(37'sd7);
    send_rect(5'd1, 5'd1, 5'd1, 5'd1, 3'sd1, 1'b1, 10'd26, 10'd27, 10'd52, 10'd51);
    give_rsum(35'sd7);
    wait_idle();

    step(2);
    check("addr_q_empty", longint'(addr_q.size()), 0);
    check("wt_q_empty", longint'(wt_q.size()), 0);
    check("feat_q_empty", longint'(feat_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/haar_feature_seq.md
Name: haar_feature_seq

Overview:
- Sequencer for the rectangle-sum datapath in the cascade classifier.
- Accepts a stream of Haar rectangle descriptors and, for each rectangle, issues the four integral-image corner addresses in the sign order the rect-sum datapath expects (+ - + -).
- Presents the rectangle weight, collects the weighted rectangle sum, and accumulates all rectangles of one feature into a single feature sum for the stage comparator.

Parameters:
- IMG_W, 25: integral-window row pitch in words (24x24 window plus zero row/column).
- W_ADDR, 10: integral memory address width.
- W_COORD, 5: width of the x/y/w/h fields.
- W_WEIGHT, 3: signed rectangle weight width.
- W_RSUM, 35: signed width of a weighted rectangle sum.
- W_FEAT, 37: signed feature accumulator width (W_RSUM+2, for up to 4 rectangles).

Ports:
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- rect_valid in 1: descriptor valid.
- rect_ready out 1: descriptor accept.
- rect_x in W_COORD: rectangle left column.
- rect_y in W_COORD: rectangle top row.
- rect_w in W_COORD: rectangle width.
- rect_h in W_COORD: rectangle height.
- rect_weight in W_WEIGHT (signed): rectangle weight.
- rect_last in 1: last rectangle of the feature.
- addr_valid out 1: corner address valid, to integral memory.
- addr_ready in 1: memory accepts address.
- addr out W_ADDR: corner address.
- weight_valid out 1: weight valid, to rect-sum datapath.
- weight_ready in 1: datapath consumed weight.
- weight out W_WEIGHT (signed): registered rect_weight.
- rsum_valid in 1: weighted rectangle sum valid, from datapath.
- rsum_ready out 1: sequencer accepts sum.
- rsum_data in W_RSUM (signed): weighted rectangle sum.
- feat_valid out 1: feature sum valid.
- feat_ready in 1: consumer accepts feature sum.
- feat_sum out W_FEAT (signed): accumulated feature sum.
- err out 1: sticky; descriptor exceeded window bounds.
- busy out 1: high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, corner count=0, accumulator=0, all valid/ready outputs 0, addr=0, weight=0, feat_sum=0, err=0. Reset mid-operation abandons the feature; no partial feat_valid is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - rect_ready=1.
  - On rect_valid&rect_ready, register x, y, w, h, weight and last; go to ISSUE with corner count=0.
  - If this is the first rectangle of a feature, clear the accumulator in the same cycle.
- ISSUE:
  - addr_valid=1. Corners are issued in order 0:(x,y), 1:(x+w,y), 2:(x+w,y+h), 3:(x,y+h).
  - addr = row*IMG_W + col, computed at full width and then truncated to W_ADDR.
  - addr is registered and held stable while addr_valid & !addr_ready.
  - Corner count advances only on addr_valid&addr_ready. After corner 3 is accepted, go to WAIT.
  - Minimum 4 cycles in ISSUE.
- Weight handshake: weight_valid rises on the cycle of entry to WAIT, holds until weight_valid&weight_ready, then drops. weight stays stable while valid.
- WAIT:
  - rsum_ready=1.
  - On rsum_valid, feature accumulator += sign-extended rsum_data.
  - If last=1, go to DONE; otherwise go to IDLE.
  - If rsum_valid arrives in the same cycle as the weight handshake, both complete that cycle.
  - rsum_valid arriving outside WAIT is ignored (rsum_ready=0).
- DONE:
  - feat_valid=1, feat_sum=accumulator; both held until feat_ready.
  - On the handshake, go to IDLE and mark the next rectangle as first-of-feature.
- Bounds check: if x+w>IMG_W-1 or y+h>IMG_W-1 at descriptor accept, set err (sticky until reset). The rectangle is still processed.
- Zero-size rectangle (w=0 or h=0): corners are still issued; the resulting sum is naturally 0.
- Accumulator arithmetic: two's complement, no saturation. Overflow is impossible for at most 4 rectangles at default widths.
- One rectangle in flight at a time; rect_ready=0 outside IDLE.

Test Plan:
- Single rectangle: x=2,y=3,w=4,h=5,weight=-1,last=1, addr_ready=1 -> addresses 77, 81, 206, 202 on 4 consecutive cycles. Then weight_valid with weight=-1. Then rsum_data=-4096*40 -> feat_sum=-163840, feat_valid held until feat_ready.
- Two-rectangle feature: weights -1 and +2 with rsum -1000 then +3000 -> exactly one feat_valid, feat_sum=2000. The next feature starts from an accumulator of 0.
- Backpressure: addr_ready toggling 1,0,0,1,... -> each address held stable until accepted, order unchanged. feat_ready low for 5 cycles -> feat_sum stable throughout, rect_ready=0.
- Out of bounds: x=20,w=8 -> err=1 and stays set. addr for corner 1 = 3*25+28 truncated per rule. Feature still completes.
- Async reset: assert rst_n=0 mid-ISSUE (after corner 1) -> outputs cleared immediately without a clock edge. The next descriptor restarts at corner 0, and the accumulator starts from 0.
- rsum_valid pulse while in ISSUE -> ignored: accumulator unchanged, rsum_ready=0.
